// File: rtl/gpr_wb_ctrl.sv
// Write-back controller: arbitrates pipeline (A) and mult/div (B) writes into an in-order FIFO
// and retires one entry per cycle onto the single GPR write port, with a per-register Busy map.
module gpr_wb_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_a_valid,
    output logic            o_a_ready,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    input  logic            i_a_ofwren,
    input  logic            i_a_offlag,
    input  logic            i_b_valid,
    output logic            o_b_ready,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    input  logic            i_wb_hold,
    output logic            o_wr_en,
    output logic            o_of_wr_en,
    output logic            o_of_flag,
    output logic [AW-1:0]   o_wr_addr,
    output logic [DW-1:0]   o_wr_data,
    output logic [2**AW-1:0] o_busy,
    output logic            o_empty,
    output logic            o_full
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OfReg = 30;

    logic [AW-1:0]    r_addr  [DEPTH];
    logic [DW-1:0]    r_data  [DEPTH];
    logic [DEPTH-1:0] r_ofw;
    logic [DEPTH-1:0] r_off;
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_a_fire;
    logic             w_b_fire;
    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_req_addr;
    logic [DW-1:0]    w_req_data;
    logic             w_req_ofw;
    logic             w_req_off;
    logic [2**AW-1:0] w_busy;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign o_full  = w_full;
    assign o_empty = w_empty;

    // B has fixed priority; neither source is ready while reset is asserted.
    assign o_b_ready = rst_n & ~w_full;
    assign o_a_ready = rst_n & ~w_full & ~i_b_valid;
    assign w_b_fire  = i_b_valid & o_b_ready;
    assign w_a_fire  = i_a_valid & o_a_ready;

    always_comb begin
        w_req_addr = i_a_addr;
        w_req_data = i_a_data;
        w_req_ofw  = i_a_ofwren;
        w_req_off  = i_a_offlag;
        if (w_b_fire) begin
            w_req_addr = i_b_addr;
            w_req_data = i_b_data;
            w_req_ofw  = 1'b0;
            w_req_off  = 1'b0;
        end
    end

    // Writes to $0 without overflow side effect are accepted and silently dropped.
    assign w_push = (w_a_fire | w_b_fire) & ~((w_req_addr == '0) & ~w_req_ofw);
    assign w_pop  = ~w_empty & ~i_wb_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_ofw   <= '0;
            r_off   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_addr[r_wptr]  <= w_req_addr;
                r_data[r_wptr]  <= w_req_data;
                r_ofw[r_wptr]   <= w_req_ofw;
                r_off[r_wptr]   <= w_req_off;
                r_valid[r_wptr] <= 1'b1;
                r_wptr          <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= r_rptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_comb begin
        o_wr_en    = 1'b0;
        o_of_wr_en = 1'b0;
        o_of_flag  = 1'b0;
        o_wr_addr  = '0;
        o_wr_data  = '0;
        if (w_pop) begin
            o_wr_en    = 1'b1;
            o_of_wr_en = r_ofw[r_rptr];
            o_of_flag  = r_off[r_rptr];
            o_wr_addr  = r_addr[r_rptr];
            o_wr_data  = r_data[r_rptr];
        end
    end

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i]) begin
                w_busy[r_addr[i]] = 1'b1;
                if (r_ofw[i]) begin
                    w_busy[OfReg] = 1'b1;
                end
            end
        end
        w_busy[0] = 1'b0;
    end

    assign o_busy = w_busy;

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Directed self-checking bench for gpr_wb_ctrl with a small behavioural GPR downstream of the port.
module tb_gpr_wb_ctrl;

    logic        clk;
    logic        rst_n;
    logic        a_valid, a_ready, a_ofw, a_off;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid, b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        wb_hold;
    logic        wr_en, of_wr_en, of_flag;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] busy;
    logic        empty, full;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int snap;
    logic [31:0] gpr [32];

    gpr_wb_ctrl #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_a_valid  (a_valid),
        .o_a_ready  (a_ready),
        .i_a_addr   (a_addr),
        .i_a_data   (a_data),
        .i_a_ofwren (a_ofw),
        .i_a_offlag (a_off),
        .i_b_valid  (b_valid),
        .o_b_ready  (b_ready),
        .i_b_addr   (b_addr),
        .i_b_data   (b_data),
        .i_wb_hold  (wb_hold),
        .o_wr_en    (wr_en),
        .o_of_wr_en (of_wr_en),
        .o_of_flag  (of_flag),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .o_busy     (busy),
        .o_empty    (empty),
        .o_full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural GPR: overflow writes set $30[0] and suppress the destination update.
    always @(posedge clk) begin
        if (wr_en) begin
            wr_count <= wr_count + 1;
            if (of_wr_en) gpr[30][0] <= of_flag;
            if (!(of_wr_en && of_flag) && wr_addr != 5'd0) gpr[wr_addr] <= wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) gpr[i] = '0;
        rst_n = 1'b0; a_valid = 0; a_ofw = 0; a_off = 0; a_addr = '0; a_data = '0;
        b_valid = 0; b_addr = '0; b_data = '0; wb_hold = 0;
        #2;
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Mid-stream reset discards three held entries.
        wb_hold = 1;
        for (int r = 9; r <= 11; r++) begin
            a_valid = 1; a_addr = 5'(r); a_data = 32'(r);
            tick();
        end
        a_valid = 0;
        chk("pre_rst_busy", busy, 32'h0000_0E00);
        snap = wr_count;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("midrst_busy", busy, 32'd0);
        chk("midrst_empty", {31'd0, empty}, 32'd1);
        @(negedge clk) rst_n = 1'b1;
        wb_hold = 0;
        tick(); tick(); tick();
        chk("midrst_no_write", 32'(wr_count - snap), 32'd0);

        // Single write, one-cycle latency.
        a_valid = 1; a_addr = 5'd5; a_data = 32'h1234_5678;
        #1 chk("single_a_ready", {31'd0, a_ready}, 32'd1);
        tick();
        a_valid = 0;
        chk("single_wr_en", {31'd0, wr_en}, 32'd1);
        chk("single_wr_addr", {27'd0, wr_addr}, 32'd5);
        chk("single_wr_data", wr_data, 32'h1234_5678);
        chk("single_busy", busy, 32'h0000_0020);
        tick();
        chk("single_busy_clr", busy, 32'd0);
        chk("single_wr_en_clr", {31'd0, wr_en}, 32'd0);
        chk("single_gpr5", gpr[5], 32'h1234_5678);

        // Back-pressure: fill under hold, then drain in order while a 5th request waits.
        wb_hold = 1;
        for (int r = 1; r <= 4; r++) begin
            a_valid = 1; a_addr = 5'(r); a_data = (32'(r) << 3) ^ 32'h1234_5678;
            tick();
        end
        a_addr = 5'd6; a_data = 32'hCAFE_0006;
        #1;
        chk("bp_full", {31'd0, full}, 32'd1);
        chk("bp_a_ready", {31'd0, a_ready}, 32'd0);
        chk("bp_b_ready", {31'd0, b_ready}, 32'd0);
        chk("bp_busy", busy, 32'h0000_001E);
        tick();
        chk("bp_still_full", {31'd0, full}, 32'd1);
        wb_hold = 0;
        #1;
        chk("bp_wr1", {26'd0, wr_en, wr_addr}, {26'd0, 1'b1, 5'd1});
        chk("bp_data1", wr_data, 32'h1234_5670);
        chk("bp_a_ready_full", {31'd0, a_ready}, 32'd0);
        tick();
        chk("bp_full_drop", {31'd0, full}, 32'd0);
        chk("bp_a_ready_5th", {31'd0, a_ready}, 32'd1);
        chk("bp_wr2", {26'd0, wr_en, wr_addr}, {26'd0, 1'b1, 5'd2});
        chk("bp_data2", wr_data, 32'h1234_5668);
        tick();
        a_valid = 0;
        chk("bp_wr3", {26'd0, wr_en, wr_addr}, {26'd0, 1'b1, 5'd3});
        chk("bp_data3", wr_data, 32'h1234_5660);
        tick();
        chk("bp_wr4", {26'd0, wr_en, wr_addr}, {26'd0, 1'b1, 5'd4});
        chk("bp_data4", wr_data, 32'h1234_5658);
        tick();
        chk("bp_wr5", {26'd0, wr_en, wr_addr}, {26'd0, 1'b1, 5'd6});
        chk("bp_data5", wr_data, 32'hCAFE_0006);
        tick();
        chk("bp_empty", {31'd0, empty}, 32'd1);
        chk("bp_gpr3", gpr[3], 32'h1234_5660);
        chk("bp_gpr6", gpr[6], 32'hCAFE_0006);

        // Arbitration: B wins, A follows next cycle.
        a_valid = 1; a_addr = 5'd7; a_data = 32'hAAAA_0007; a_ofw = 0; a_off = 0;
        b_valid = 1; b_addr = 5'd8; b_data = 32'hBBBB_0008;
        #1;
        chk("arb_b_ready", {31'd0, b_ready}, 32'd1);
        chk("arb_a_blocked", {31'd0, a_ready}, 32'd0);
        tick();
        b_valid = 0;
        #1;
        chk("arb_a_ready", {31'd0, a_ready}, 32'd1);
        chk("arb_first", {26'd0, wr_en, wr_addr}, {26'd0, 1'b1, 5'd8});
        tick();
        a_valid = 0;
        chk("arb_second", {26'd0, wr_en, wr_addr}, {26'd0, 1'b1, 5'd7});
        chk("arb_data2", wr_data, 32'hAAAA_0007);
        tick();
        chk("arb_gpr8", gpr[8], 32'hBBBB_0008);
        chk("arb_gpr7", gpr[7], 32'hAAAA_0007);

        // Overflow write: flags $30, leaves destination untouched.
        wb_hold = 1;
        a_valid = 1; a_addr = 5'd2; a_data = 32'h8765_4321; a_ofw = 1; a_off = 1;
        tick();
        a_valid = 0;
        chk("of_busy", busy, 32'h4000_0004);
        chk("of_held_wr_en", {30'd0, wr_en, of_wr_en}, 32'd0);
        wb_hold = 0;
        #1;
        chk("of_port", {29'd0, wr_en, of_wr_en, of_flag}, 32'd7);
        tick();
        chk("of_gpr2_kept", gpr[2], 32'h1234_5668);
        chk("of_gpr30", {31'd0, gpr[30][0]}, 32'd1);
        a_valid = 1; a_off = 0;
        tick();
        a_valid = 0;
        chk("nof_port", {29'd0, wr_en, of_wr_en, of_flag}, 32'd6);
        tick();
        chk("nof_gpr2", gpr[2], 32'h8765_4321);
        chk("nof_gpr30", {31'd0, gpr[30][0]}, 32'd0);

        // $0 without overflow is dropped; with overflow it is queued.
        snap = wr_count;
        a_valid = 1; a_addr = 5'd0; a_data = 32'hDEAD_BEEF; a_ofw = 0; a_off = 0;
        #1 chk("zero_a_ready", {31'd0, a_ready}, 32'd1);
        tick();
        a_valid = 0;
        chk("zero_empty", {31'd0, empty}, 32'd1);
        chk("zero_wr_en", {31'd0, wr_en}, 32'd0);
        tick();
        chk("zero_no_write", 32'(wr_count - snap), 32'd0);
        wb_hold = 1;
        a_valid = 1; a_ofw = 1; a_off = 1;
        tick();
        a_valid = 0; a_ofw = 0; a_off = 0;
        chk("zero_of_queued", {31'd0, empty}, 32'd0);
        chk("zero_of_busy", busy, 32'h4000_0000);
        wb_hold = 0;
        tick();
        chk("zero_of_gpr30", {31'd0, gpr[30][0]}, 32'd1);
        chk("zero_gpr0", gpr[0], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
